alu_mul_sequencer: RTL and testbench

// - Multi-cycle shift-add sequencer that runs MUL/MULS on the shared execute-stage ALU.
// - On start it takes the ALU away from the pipeline: it drives the ALU control, the input selects
//   and update_flag, and feeds the accumulator/operand values itself. It asserts stall_o until done.
// - Sits in execute between the decode-stage control signals and the ALU wrapper input muxes.

---
 rtl/alu_mul_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL/MULS sequencer that borrows the execute-stage ALU for one add per multiplier bit.
// Optional early exit on an exhausted multiplier (and iter_cnt_o) is enabled by ALU_MUL_EARLY_TERM_EN.
module alu_mul_sequencer #(
    parameter int                WORD     = 32,
    parameter int                CTRL_W   = 4,
    parameter int                SEL_W    = 3,
    parameter logic [CTRL_W-1:0] CTRL_ADD = 4'd0,
    parameter logic [SEL_W-1:0]  SEL_ACC  = 3'd3,
    parameter logic [SEL_W-1:0]  SEL_REG  = 3'd0,
    parameter logic [SEL_W-1:0]  SEL_ZERO = 3'd2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       set_flags_i,
    input  logic [WORD-1:0]            multiplicand_i,
    input  logic [WORD-1:0]            multiplier_i,
    input  logic [WORD-1:0]            alu_result_i,
    output logic                       alu_override_o,
    output logic [CTRL_W-1:0]          alu_ctrl_o,
    output logic [SEL_W-1:0]           alu_in1_sel_o,
    output logic [SEL_W-1:0]           alu_in2_sel_o,
    output logic [WORD-1:0]            acc_o,
    output logic [WORD-1:0]            operand_o,
    output logic                       update_flag_o,
    output logic                       stall_o,
    output logic                       done_o,
`ifdef ALU_MUL_EARLY_TERM_EN
    output logic [$clog2(WORD+1)-1:0]  iter_cnt_o,
`endif
    output logic [WORD-1:0]            result_o
);

    localparam int CNT_W = $clog2(WORD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WORD-1:0]  acc_reg, acc_next;
    logic [WORD-1:0]  mcand_reg, mcand_next;
    logic [WORD-1:0]  mplier_reg, mplier_next;
    logic [WORD-1:0]  result_reg, result_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             flags_reg, flags_next;
    logic             last_iter;

`ifdef ALU_MUL_EARLY_TERM_EN
    logic [CNT_W-1:0] iter_reg, iter_next;

    // Stop once no set multiplier bits remain above the one consumed this cycle.
    assign last_iter = (count_reg == CNT_W'(WORD - 1)) || ((mplier_reg >> 1) == '0);
    assign iter_cnt_o = iter_reg;
`else
    assign last_iter = (count_reg == CNT_W'(WORD - 1));
`endif

    // Bypass makes the product visible during the done pulse itself; an abort keeps the old value.
    assign result_o = (state_reg == FINISH && !abort_i) ? acc_reg : result_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            result_reg <= '0;
            count_reg  <= '0;
            flags_reg  <= 1'b0;
`ifdef ALU_MUL_EARLY_TERM_EN
            iter_reg   <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            result_reg <= result_next;
            count_reg  <= count_next;
            flags_reg  <= flags_next;
`ifdef ALU_MUL_EARLY_TERM_EN
            iter_reg   <= iter_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        result_next    = result_reg;
        count_next     = count_reg;
        flags_next     = flags_reg;
`ifdef ALU_MUL_EARLY_TERM_EN
        iter_next      = iter_reg;
`endif
        alu_override_o = 1'b0;
        alu_ctrl_o     = '0;
        alu_in1_sel_o  = SEL_ZERO;
        alu_in2_sel_o  = SEL_ZERO;
        acc_o          = '0;
        operand_o      = '0;
        update_flag_o  = 1'b0;
        stall_o        = 1'b0;
        done_o         = 1'b0;

        case (state_reg)
            IDLE: begin
                // A flush arriving with the request cancels the request.
                if (start_i && !abort_i) begin
                    acc_next    = '0;
                    mcand_next  = multiplicand_i;
                    mplier_next = multiplier_i;
                    count_next  = '0;
                    flags_next  = set_flags_i;
                    state_next  = RUN;
                end
            end

            RUN: begin
                alu_override_o = 1'b1;
                alu_ctrl_o     = CTRL_ADD;
                alu_in1_sel_o  = SEL_ACC;
                alu_in2_sel_o  = SEL_REG;
                acc_o          = acc_reg;
                operand_o      = mcand_reg;
                stall_o        = 1'b1;
                if (abort_i) begin
                    state_next = IDLE;
                end else begin
                    if (mplier_reg[0]) begin
                        acc_next = alu_result_i;
                    end
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    count_next  = count_reg + 1'b1;
                    if (last_iter) begin
`ifdef ALU_MUL_EARLY_TERM_EN
                        iter_next = count_reg + 1'b1;
`endif
                        state_next = FINISH;
                    end
                end
            end

            FINISH: begin
                // acc + 0 through the ALU sets N/Z from the product and clears C/V.
                alu_override_o = 1'b1;
                alu_ctrl_o     = CTRL_ADD;
                alu_in1_sel_o  = SEL_ACC;
                alu_in2_sel_o  = SEL_ZERO;
                acc_o          = acc_reg;
                stall_o        = 1'b1;
                state_next     = IDLE;
                if (!abort_i) begin
                    update_flag_o = flags_reg;
                    done_o        = 1'b1;
                    result_next   = acc_reg;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer: a behavioural ALU/flag register plus an arithmetic product model.
// Builds with or without ALU_MUL_EARLY_TERM_EN.
module tb_alu_mul_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        start_i;
    logic        abort_i;
    logic        set_flags_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic [31:0] alu_result_i;
    logic        alu_override_o;
    logic [3:0]  alu_ctrl_o;
    logic [2:0]  alu_in1_sel_o;
    logic [2:0]  alu_in2_sel_o;
    logic [31:0] acc_o;
    logic [31:0] operand_o;
    logic        update_flag_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
`ifdef ALU_MUL_EARLY_TERM_EN
    logic [5:0]  iter_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    alu_mul_sequencer dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .set_flags_i    (set_flags_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .alu_result_i   (alu_result_i),
        .alu_override_o (alu_override_o),
        .alu_ctrl_o     (alu_ctrl_o),
        .alu_in1_sel_o  (alu_in1_sel_o),
        .alu_in2_sel_o  (alu_in2_sel_o),
        .acc_o          (acc_o),
        .operand_o      (operand_o),
        .update_flag_o  (update_flag_o),
        .stall_o        (stall_o),
        .done_o         (done_o),
`ifdef ALU_MUL_EARLY_TERM_EN
        .iter_cnt_o     (iter_cnt_o),
`endif
        .result_o       (result_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU wrapper: input muxes, ADD (anything else gives XOR), pipeline value when not overridden.
    logic [31:0] in1_v, in2_v;
    logic [32:0] sum_v;
    always_comb begin
        case (alu_in1_sel_o)
            3'd3:    in1_v = acc_o;
            3'd0:    in1_v = 32'h1357_9BDF;
            3'd2:    in1_v = 32'h0;
            default: in1_v = 32'hBAD0_BAD0;
        endcase
        case (alu_in2_sel_o)
            3'd3:    in2_v = acc_o;
            3'd0:    in2_v = operand_o;
            3'd2:    in2_v = 32'h0;
            default: in2_v = 32'hBAD1_BAD1;
        endcase
        sum_v = {1'b0, in1_v} + {1'b0, in2_v};
        if (!alu_override_o)
            alu_result_i = 32'h0F0F_0F0F;
        else if (alu_ctrl_o == 4'd0)
            alu_result_i = sum_v[31:0];
        else
            alu_result_i = in1_v ^ in2_v;
    end

    // Status register {N,Z,C,V}
    logic [3:0] flags   = 4'b1011;
    int         upd_cnt = 0;
    always @(posedge clk_i) begin
        if (update_flag_o) begin
            flags   <= {alu_result_i[31], alu_result_i == 32'h0, sum_v[32],
                        (in1_v[31] == in2_v[31]) && (alu_result_i[31] != in1_v[31])};
            upd_cnt <= upd_cnt + 1;
        end
    end

    function automatic int exp_iters(input logic [31:0] b);
        int n;
        n = 32;
`ifdef ALU_MUL_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) n = i + 1;
`endif
        return n;
    endfunction

    // Drives one multiply and observes it; cycle c is the c-th clock period after the start edge.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic sf,
                          input int restart_at, input int abort_at, input int window,
                          output logic [31:0] res_at_done, output int done_cyc, output int done_cnt,
                          output int stall_err, output int upd_err, output logic first_stall);
        int iters, lim, busy_to;
        @(negedge clk_i);
        first_stall    = stall_o;
        multiplicand_i = a;
        multiplier_i   = b;
        set_flags_i    = sf;
        start_i        = 1'b1;
        @(posedge clk_i);
        #1;
        start_i        = 1'b0;
        multiplicand_i = $urandom;
        multiplier_i   = $urandom;
        set_flags_i    = ~sf;
        iters       = exp_iters(b);
        busy_to     = (abort_at > 0) ? abort_at : iters + 1;
        lim         = (window > 0) ? window : 80;
        res_at_done = 32'hx;
        done_cyc    = -1;
        done_cnt    = 0;
        stall_err   = 0;
        upd_err     = 0;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    res_at_done = result_o;
                end
            end
            if (stall_o !== (c <= busy_to)) stall_err++;
            if (update_flag_o !== ((abort_at == 0 && c == iters + 1) ? sf : 1'b0)) upd_err++;
            if (c == restart_at) begin
                start_i        = 1'b1;
                multiplicand_i = a ^ 32'h5A5A_0001;
                multiplier_i   = ~b;
            end
            if (c == abort_at) abort_i = 1'b1;
            if (start_i || abort_i) begin
                @(posedge clk_i);
                #1;
                start_i = 1'b0;
                abort_i = 1'b0;
            end
            if (window == 0 && done_cyc > 0) break;
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; set_flags_i = 1'b0;
        multiplicand_i = 32'h0; multiplier_i = 32'h0;
        repeat (3) @(negedge clk_i);
        total++;
        if ({alu_override_o, update_flag_o, stall_o, done_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got ovr/upd/stall/done=%b expected 0000",
                     {alu_override_o, update_flag_o, stall_o, done_o});
        end
        total++;
        if ({alu_ctrl_o, alu_in1_sel_o, alu_in2_sel_o} !== {4'd0, 3'd2, 3'd2}) begin
            bad++;
            $display("FAIL reset_sel: got ctrl=%0d in1=%0d in2=%0d expected 0 2 2",
                     alu_ctrl_o, alu_in1_sel_o, alu_in2_sel_o);
        end
        total++;
        if ({acc_o, operand_o, result_o} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data: got acc=%h op=%h res=%h expected 0", acc_o, operand_o, result_o);
        end
        reset_n_i = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_directed();
        logic [31:0] av [4] = '{32'd7, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0001_0000};
        logic [31:0] bv [4] = '{32'd6, 32'hFFFF_FFFF, 32'h0,         32'h0000_8000};
        logic        sv [4] = '{1'b1,  1'b1,          1'b1,          1'b0};
        logic [31:0] res, prod;
        logic [3:0]  exp_flags;
        int dc, dn, se, ue, u0;
        logic fs;
        for (int i = 0; i < 4; i++) begin
            prod      = av[i] * bv[i];
            exp_flags = sv[i] ? {prod[31], prod == 32'h0, 2'b00} : flags;
            u0        = upd_cnt;
            do_mul(av[i], bv[i], sv[i], 0, 0, 0, res, dc, dn, se, ue, fs);
            $display("directed %h x %h sf=%0d: result=%h done_cycle=%0d", av[i], bv[i], sv[i], res, dc);
            total++;
            if (res !== prod) begin
                bad++;
                $display("FAIL dir_result[%0d]: got %h expected %h", i, res, prod);
            end
            total++;
            if (dc !== exp_iters(bv[i]) + 1) begin
                bad++;
                $display("FAIL dir_latency[%0d]: got cycle %0d expected %0d", i, dc, exp_iters(bv[i]) + 1);
            end
            total++;
            if (se != 0 || ue != 0) begin
                bad++;
                $display("FAIL dir_stall_upd[%0d]: got stall_err=%0d upd_err=%0d expected 0 0", i, se, ue);
            end
`ifdef ALU_MUL_EARLY_TERM_EN
            total++;
            if (iter_cnt_o !== 6'(exp_iters(bv[i]))) begin
                bad++;
                $display("FAIL dir_iter_cnt[%0d]: got %0d expected %0d", i, iter_cnt_o, exp_iters(bv[i]));
            end
`endif
            @(posedge clk_i);
            #1;
            total++;
            if (flags !== exp_flags || (upd_cnt - u0) != (sv[i] ? 1 : 0)) begin
                bad++;
                $display("FAIL dir_flags[%0d]: got NZCV=%b updates=%0d expected NZCV=%b updates=%0d",
                         i, flags, upd_cnt - u0, exp_flags, sv[i] ? 1 : 0);
            end
            total++;
            if (result_o !== prod) begin
                bad++;
                $display("FAIL dir_hold[%0d]: got %h expected %h", i, result_o, prod);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, prod;
        logic        sf, fs;
        int dc, dn, se, ue;
        for (int i = 0; i < 24; i++) begin
            a    = $urandom;
            b    = $urandom >> $urandom_range(0, 31);
            sf   = 1'($urandom_range(0, 1));
            prod = a * b;
            do_mul(a, b, sf, 0, 0, 0, res, dc, dn, se, ue, fs);
            $display("random %h x %h sf=%0d: result=%h done_cycle=%0d", a, b, sf, res, dc);
            total++;
            if (res !== prod || dc !== exp_iters(b) + 1 || se != 0 || ue != 0) begin
                bad++;
                $display("FAIL rand[%0d]: got res=%h cyc=%0d serr=%0d uerr=%0d expected res=%h cyc=%0d 0 0",
                         i, res, dc, se, ue, prod, exp_iters(b) + 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b, res, prod;
        logic fs;
        int dc, dn, se, ue;
        a = 32'hCAFE_1234;
        b = 32'h8000_0003;
        prod = a * b;
        do_mul(a, b, 1'b0, 5, 0, 75, res, dc, dn, se, ue, fs);
        $display("restart-in-run %h x %h: result=%h done_count=%0d", a, b, res, dn);
        total++;
        if (dn != 1 || res !== prod || dc != 33) begin
            bad++;
            $display("FAIL ignore_start: got done_count=%0d res=%h cyc=%0d expected 1 %h 33", dn, res, dc, prod);
        end
        total++;
        if (se != 0 || ue != 0) begin
            bad++;
            $display("FAIL ignore_start_stall: got stall_err=%0d upd_err=%0d expected 0 0", se, ue);
        end
    endtask

    task automatic test_abort();
        logic [31:0] res, held;
        logic fs;
        int dc, dn, se, ue, u0;
        held = result_o;
        u0   = upd_cnt;
        do_mul(32'h0000_0101, 32'hF000_0001, 1'b1, 0, 10, 45, res, dc, dn, se, ue, fs);
        $display("abort in run cycle 10: done_count=%0d result=%h", dn, result_o);
        total++;
        if (dn != 0 || result_o !== held || upd_cnt != u0) begin
            bad++;
            $display("FAIL abort: got done_count=%0d res=%h updates=%0d expected 0 %h 0",
                     dn, result_o, upd_cnt - u0, held);
        end
        total++;
        if (se != 0 || ue != 0) begin
            bad++;
            $display("FAIL abort_stall: got stall_err=%0d upd_err=%0d expected 0 0", se, ue);
        end
        // abort together with start in IDLE drops the start
        @(negedge clk_i);
        start_i = 1'b1; abort_i = 1'b1;
        multiplicand_i = 32'd3; multiplier_i = 32'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0; abort_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (stall_o !== 1'b0 || alu_override_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_with_start: got stall=%b override=%b expected 0 0", stall_o, alu_override_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, res, prod;
        logic fs;
        int dc, dn, se, ue;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom | 32'h8000_0000;
            prod = a * b;
            do_mul(a, b, 1'b1, 0, 0, 0, res, dc, dn, se, ue, fs);
            $display("back-to-back %0d: %h x %h result=%h", i, a, b, res);
            total++;
            if (res !== prod || dc != 33 || se != 0 || ue != 0) begin
                bad++;
                $display("FAIL b2b[%0d]: got res=%h cyc=%0d serr=%0d uerr=%0d expected %h 33 0 0",
                         i, res, dc, se, ue, prod);
            end
            if (i > 0) begin
                total++;
                if (fs !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_gap[%0d]: got stall=%b after done expected 0", i, fs);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] res, prod;
        logic fs;
        int dc, dn, se, ue;
        @(negedge clk_i);
        multiplicand_i = 32'h1111_2222; multiplier_i = 32'hFFFF_0000; set_flags_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (6) @(negedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        total++;
        if ({stall_o, alu_override_o, done_o, result_o} !== 35'h0) begin
            bad++;
            $display("FAIL reset_midrun: got stall=%b ovr=%b done=%b res=%h expected all 0",
                     stall_o, alu_override_o, done_o, result_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        prod = 32'h0000_ABCD * 32'h0000_1234;
        do_mul(32'h0000_ABCD, 32'h0000_1234, 1'b0, 0, 0, 0, res, dc, dn, se, ue, fs);
        $display("after mid-run reset: result=%h", res);
        total++;
        if (res !== prod || dc !== exp_iters(32'h0000_1234) + 1) begin
            bad++;
            $display("FAIL reset_recover: got res=%h cyc=%0d expected %h %0d",
                     res, dc, prod, exp_iters(32'h0000_1234) + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
